// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed common-anode seven-segment scanner.
// Takes one snapshot of i_data per frame so digits never tear mid-scan,
// gates each digit slot by a programmable duty window, and can freeze the
// snapshot with i_hold.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (leading-zero blanking).
module seg7_scan_display #(
    parameter int unsigned CLKS_PER_DIGIT = 12500
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [31:0] i_data,
    input  logic        i_hold,
    input  logic [1:0]  i_duty,
    output logic [7:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic        o_frame
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_DIGIT);
    // Wide enough to hold 4*CLKS_PER_DIGIT for the duty-window product.
    localparam int unsigned LIM_W = $clog2(4 * CLKS_PER_DIGIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_DIGIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       digit_q, digit_d;
    logic [31:0]      snap_q, snap_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_q, frame_d;

    logic             cnt_wrap_c;
    logic             boundary_c;
    logic [LIM_W-1:0] lim_c;
    logic             lit_c;
    logic             show_c;
    logic [3:0]       nib_c;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0]       blank_q, blank_d;
`endif

    // Active-low gfedcba hex glyphs.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Next-state: slot/digit scan, frame snapshot, and registered display outputs.
    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        snap_d  = snap_q;
        an_d    = 8'hFF;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        frame_d = 1'b0;

        cnt_wrap_c = (cnt_q == CNT_LAST);
        boundary_c = cnt_wrap_c && (digit_q == 3'd7);

        if (cnt_wrap_c) begin
            cnt_d   = '0;
            digit_d = digit_q + 3'd1;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
        end

        // Hold wins over a coincident frame boundary.
        if (boundary_c && !i_hold) begin
            snap_d = i_data;
        end
        frame_d = boundary_c;

        lim_c  = LIM_W'(((LIM_W'(i_duty) + LIM_W'(1)) * LIM_W'(CLKS_PER_DIGIT)) >> 2);
        lit_c  = (LIM_W'(cnt_q) < lim_c);
        nib_c  = 4'(snap_q >> {digit_q, 2'b00});

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank_d = blank_q;
        if (boundary_c) begin
            blank_d[0] = 1'b0;
            for (int k = 1; k < 8; k++) begin
                blank_d[k] = ((snap_d >> (4 * k)) == 32'd0);
            end
        end
        show_c = lit_c && !blank_q[digit_q];
`else
        show_c = lit_c;
`endif

        if (show_c) begin
            an_d  = ~(8'b1 << digit_q);
            seg_d = hex7(nib_c);
        end
        // Decimal point marks hold on digit 4; it ignores blanking.
        dp_d = !(lit_c && (digit_q == 3'd4) && i_hold);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            cnt_q   <= '0;
            digit_q <= '0;
            snap_q  <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign o_an    = an_q;
    assign o_seg   = seg_q;
    assign o_dp    = dp_q;
    assign o_frame = frame_q;

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream consumer of the 32-bit register-view bus `out`, which selects data or control register contents.
- Drives an 8-digit multiplexed common-anode seven-segment display on the board.
- Snapshots the 32-bit value once per frame so digits never tear mid-scan.
- Scans one hex nibble per digit slot, with programmable brightness and a hold/freeze input.

Parameters:
- CLKS_PER_DIGIT, default 12500: clk_in cycles per digit slot. 100 MHz gives 8 kHz per digit and a 1 kHz frame. Legal range is 4 or more.

Ports:
- clk_in  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-low
- i_data  input  32  value to display; nibble k is shown on digit k
- i_hold  input  1  when 1, the snapshot is frozen at the frame boundary
- i_duty  input  2  brightness; a digit is lit for (i_duty+1)/4 of its slot
- o_an  output  8  digit anode enables, active-low; bit k is digit k
- o_seg  output  7  segments, active-low; bit0=a .. bit6=g
- o_dp  output  1  decimal point, active-low
- o_frame  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (rst==0 at a clock edge):
  - slot counter = 0, digit index = 0, snapshot = 0.
  - o_an = 8'hFF, o_seg = 7'h7F, o_dp = 1, o_frame = 0.
- Slot counter:
  - Counts 0..CLKS_PER_DIGIT-1, then wraps to 0.
  - On wrap, digit index increments 0..7, and 7 wraps to 0.
- Frame boundary: the edge where counter==CLKS_PER_DIGIT-1 and digit==7.
  - If i_hold==0, snapshot <= i_data; otherwise snapshot is unchanged.
  - o_frame is 1 for exactly the next cycle, in both cases.
  - i_data is sampled only at this edge. Changes at any other time have no effect.
- On-window: lit = (counter < ((i_duty+1)*CLKS_PER_DIGIT)/4), computed in integer arithmetic at a width sufficient for 4*CLKS_PER_DIGIT.
  - i_duty=3 means always lit.
  - i_duty=0 means lit for the first quarter of the slot.
- Output registers: all outputs are registered and follow counter/digit/snapshot with exactly 1 cycle latency.
  - o_an = ~(8'b1 << digit) when lit, else 8'hFF.
  - o_seg = hex code of snapshot[4*digit+3 : 4*digit] when lit, else 7'h7F.
  - o_dp = 0 only when lit, digit==4 and i_hold==1; else 1.
- Hex codes, active-low in gfedcba order:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- At most one o_an bit is low in any cycle.
- i_duty is sampled every cycle. A change mid-slot takes effect on the next cycle's compare, with no glitch beyond that.
- Mid-scan reset returns to digit 0 and clears the snapshot. The display shows 00000000 until the first frame boundary completes.
- Simultaneous frame boundary and i_hold rising: hold wins and the snapshot is unchanged.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - At each frame boundary, compute and register a blank mask from the newly loaded snapshot.
  - Digit k (k = 7..1) is blanked if it and every higher nibble are 0. Digit 0 is never blanked.
  - A blanked digit drives o_an bit high and o_seg = 7'h7F for its whole slot.
  - o_dp still follows its rule, since digit 4 is blanked only when the value is below 0x10000.
- Not defined: all 8 digits are always shown; no mask logic is present.

Test Plan (CLKS_PER_DIGIT=4):
- Reset then i_data=32'h89ABCDEF, i_duty=3, i_hold=0 → first frame shows 0 (o_seg=40) on all digits. After o_frame pulses, digit 0 shows F (0E), digit 1 shows E (06), …, digit 7 shows 8 (00). o_an steps FE,FD,…,7F, 4 cycles each.
- Track o_frame across 3 frames → exactly one 1-cycle pulse every 32 cycles. No other o_frame activity.
- i_duty=0 → in each 4-cycle slot, o_an has one low bit for 1 cycle and is 8'hFF for 3 cycles. i_duty=1 → lit 2 of 4 cycles.
- Load 32'h12345678, assert i_hold, change i_data to 32'hFFFFFFFF → digits keep 12345678 across 2 frames. o_dp=0 only during digit 4's lit cycles. Release hold → next frame shows FFFFFFFF.
- Assert rst=0 for 1 cycle at digit 5 mid-slot → next cycle o_an=FF, o_seg=7F. The scan restarts at digit 0 showing 0.
- With SEG7_LEADING_ZERO_BLANK_EN and i_data=32'h00000A05 → digits 7..3 stay dark (o_an bit high), digits 2..0 show 0A05's "A05". With i_data=0, only digit 0 shows "0".
